uart_tx_frame_ctrl: RTL and testbench

- Frame controller for the UART transmitter. It sits directly upstream of the TX output multiplexer.
- Accepts a parallel byte with a valid strobe and sequences the frame: start, data LSB-first, optional parity, stop.
- Drives the multiplexer select, the serial data bit and the parity bit, and reports busy.
- CLK is the bit-rate clock: one frame bit per CLK cycle.

---
 rtl/uart_tx_frame_ctrl_if.sv | 34 +++
 rtl/uart_tx_frame_ctrl.sv | 94 +++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_ctrl_if.sv
// UART TX frame controller bus.
// Purpose: bundles the byte request (data, strobe, parity config) and the
//          frame-sequencing outputs between the requester and the controller.
// Signals:
//   P_DATA     parallel byte to transmit
//   Data_Valid transmit request
//   PAR_EN     insert parity bit after the data bits
//   PAR_TYP    0 = even parity, 1 = odd parity
//   mux_sel    TX output-mux select (000 start, 001 data, 010 parity, 011 stop, 101 idle)
//   ser_data   current data bit
//   par_bit    parity of the current/last accepted frame
//   busy       frame in progress (start through stop)
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [2:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller.
// Purpose: accepts a byte on Data_Valid while idle and sequences one frame
//          (start, data LSB-first, optional parity, stop), one bit per CLK.
// Ports:
//   CLK  bit-rate clock, rising edge
//   RST  synchronous reset, active-high
//   bus  uart_tx_frame_ctrl_if.slave (request inputs, mux_sel/ser_data/par_bit/busy)
//
// state  | meaning
// IDLE   | line idle, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PAR_EN latched)
// STOP   | stop bit, requests ignored
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_frame_ctrl_if.slave  bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    // Encodings equal the mux_sel codes so the select is the state register.
    typedef enum logic [2:0] {
        S_START  = 3'b000,
        S_DATA   = 3'b001,
        S_PARITY = 3'b010,
        S_STOP   = 3'b011,
        S_IDLE   = 3'b101
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    shift_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                // Zero fill leaves ser_data at 0 once the byte is out.
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign bus.mux_sel  = state_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ser_data = shift_q[0];
    assign bus.par_bit  = par_bit_q;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
module tb_uart_tx_frame_ctrl;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Walks n cycles after an accept edge, sampling on the falling edge.
    // Cycle i is compared against mux[i], ser_v[i] and busy_v[i].
    task automatic walk(input string tag, input int n, input logic [2:0] mux [16],
                        input logic [15:0] ser_v, input logic [15:0] busy_v,
                        input bit drop_dv, input int chg_at);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.mux_sel !== mux[i]) begin
                failures++;
                $display("FAIL %s mux_sel cycle %0d: got %b want %b", tag, i, bus.mux_sel, mux[i]);
            end
            checks++;
            if (bus.ser_data !== ser_v[i]) begin
                failures++;
                $display("FAIL %s ser_data cycle %0d: got %b want %b", tag, i, bus.ser_data, ser_v[i]);
            end
            checks++;
            if (bus.busy !== busy_v[i]) begin
                failures++;
                $display("FAIL %s busy cycle %0d: got %b want %b", tag, i, bus.busy, busy_v[i]);
            end
            if (i == 0 && drop_dv) bus.Data_Valid = 1'b0;
            if (i == chg_at) begin
                bus.P_DATA  = 8'hFF;
                bus.PAR_TYP = ~bus.PAR_TYP;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle timeout: busy got %b want 0", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'hA5;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.mux_sel !== 3'b101) begin failures++; $display("FAIL reset mux_sel: got %b want 101", bus.mux_sel); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.ser_data !== 1'b0) begin failures++; $display("FAIL reset ser_data: got %b want 0", bus.ser_data); end
        checks++;
        if (bus.par_bit !== 1'b0) begin failures++; $display("FAIL reset par_bit: got %b want 0", bus.par_bit); end
        RST = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.PAR_TYP = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.mux_sel !== 3'b101) begin failures++; $display("FAIL reset_no_frame mux_sel: got %b want 101", bus.mux_sel); end
    endtask

    // A5, parity enabled, even: 000, 001x8, 010, 011, 101; data 1,0,1,0,0,1,0,1
    task automatic test_a5_parity();
        logic [2:0] m [16];
        for (int i = 0; i < 16; i++) m[i] = 3'b101;
        m[0] = 3'b000;
        for (int i = 1; i <= 8; i++) m[i] = 3'b001;
        m[9] = 3'b010;
        m[10] = 3'b011;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'hA5;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        walk("a5", 12, m, 16'h014B, 16'h07FF, 1'b1, -1);
        checks++;
        if (bus.par_bit !== 1'b0) begin failures++; $display("FAIL a5 par_bit: got %b want 0", bus.par_bit); end
    endtask

    task automatic test_parity_type();
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'h01;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        checks++;
        if (bus.par_bit !== 1'b1) begin failures++; $display("FAIL par_even_01: got %b want 1", bus.par_bit); end
        wait_idle("par_even_01");
        bus.Data_Valid = 1'b1;
        bus.PAR_TYP = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        checks++;
        if (bus.par_bit !== 1'b0) begin failures++; $display("FAIL par_odd_01: got %b want 0", bus.par_bit); end
        wait_idle("par_odd_01");
        checks++;
        if (bus.par_bit !== 1'b0) begin failures++; $display("FAIL par_odd_01_hold: got %b want 0", bus.par_bit); end
    endtask

    // FF, no parity, Data_Valid held: 000, 001x8, 011, 101, 000 (restart)
    task automatic test_back_to_back();
        logic [2:0] m [16];
        for (int i = 0; i < 16; i++) m[i] = 3'b101;
        m[0] = 3'b000;
        for (int i = 1; i <= 8; i++) m[i] = 3'b001;
        m[9] = 3'b011;
        m[10] = 3'b101;
        m[11] = 3'b000;
        @(negedge CLK);
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'hFF;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        walk("b2b", 12, m, 16'h09FF, 16'h0BFF, 1'b0, -1);
        bus.Data_Valid = 1'b0;
        wait_idle("b2b");
    endtask

    // 3C frame; P_DATA and PAR_TYP change during DATA and must be ignored
    task automatic test_input_change();
        logic [2:0] m [16];
        for (int i = 0; i < 16; i++) m[i] = 3'b101;
        m[0] = 3'b000;
        for (int i = 1; i <= 8; i++) m[i] = 3'b001;
        m[9] = 3'b010;
        m[10] = 3'b011;
        @(negedge CLK);
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        walk("chg", 12, m, 16'h0078, 16'h07FF, 1'b1, 2);
        checks++;
        if (bus.par_bit !== 1'b0) begin failures++; $display("FAIL chg par_bit: got %b want 0", bus.par_bit); end
        bus.PAR_TYP = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] m [16];
        for (int i = 0; i < 16; i++) m[i] = 3'b001;
        m[0] = 3'b000;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'hA5;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        walk("rmid_pre", 4, m, 16'h000B, 16'h000F, 1'b1, -1);
        @(negedge CLK);
        checks++;
        if (bus.mux_sel !== 3'b001) begin failures++; $display("FAIL rmid 4th data mux_sel: got %b want 001", bus.mux_sel); end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (bus.mux_sel !== 3'b101) begin failures++; $display("FAIL rmid mux_sel: got %b want 101", bus.mux_sel); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.ser_data !== 1'b0) begin failures++; $display("FAIL rmid ser_data: got %b want 0", bus.ser_data); end
        @(negedge CLK);
        checks++;
        if (bus.mux_sel !== 3'b101) begin failures++; $display("FAIL rmid abort mux_sel: got %b want 101", bus.mux_sel); end
        // 55 odd parity: four ones -> par_bit 1
        for (int i = 0; i < 16; i++) m[i] = 3'b101;
        m[0] = 3'b000;
        for (int i = 1; i <= 8; i++) m[i] = 3'b001;
        m[9] = 3'b010;
        m[10] = 3'b011;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'h55;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        walk("rmid_55", 12, m, 16'h00AB, 16'h07FF, 1'b1, -1);
        checks++;
        if (bus.par_bit !== 1'b1) begin failures++; $display("FAIL rmid_55 par_bit: got %b want 1", bus.par_bit); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RST = 1'b1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        test_reset();
        test_a5_parity();
        test_parity_type();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
